// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 12;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Even parity bit: makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy flags and an overflow pulse.
// Reads are show-ahead: o_data always presents the head entry.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count,
    output logic             o_overflow
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [AW:0]      w_count_next;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees room for a push.
    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && !r_empty;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers, occupancy, flags and overflow pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count    <= w_count_next;
            r_full     <= (w_count_next == CNT_FULL);
            r_empty    <= (w_count_next == '0);
            r_overflow <= i_push && r_full;
        end
    end

    assign o_data     = r_mem[r_rptr];
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed framer producing start, 8 data bits
// (LSB first), optional even parity and stop bit on a registered TX line.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              PCLK,
    input  logic              RESET,
    input  logic              WR_EN,
    input  logic [DATA_W-1:0] DATA_TX_I,
    input  logic [DIV_W-1:0]  WORK_FR,
    input  logic              PARITY_EN,
    output logic              TX_O,
    output logic              FULL,
    output logic              EMPTY,
    output logic [AW:0]       COUNT,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERFLOW
);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  w_div_next;
    logic [DIV_W-1:0]  r_timer;
    logic [DIV_W-1:0]  w_timer_next;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_cnt_next;
    logic              r_par_en;
    logic              w_par_en_next;
    logic              r_par;
    logic              w_par_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_done;
    logic              w_done_next;
    logic              r_busy;

    logic              w_bit_end;
    logic              w_start;
    logic              w_pop;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W),
        .AW    (AW)
    ) u_fifo (
        .i_clk      (PCLK),
        .i_rst      (RESET),
        .i_push     (WR_EN),
        .i_data     (DATA_TX_I),
        .i_pop      (w_pop),
        .o_data     (w_fifo_data),
        .o_full     (FULL),
        .o_empty    (w_empty),
        .o_count    (COUNT),
        .o_overflow (OVERFLOW)
    );

    assign EMPTY     = w_empty;
    assign w_bit_end = (r_timer == 12'd0);

    // Framing FSM next state, bit timer, shifter and next registered line value.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_div_next     = r_div;
        w_timer_next   = r_timer;
        w_bit_cnt_next = r_bit_cnt;
        w_par_en_next  = r_par_en;
        w_par_next     = r_par;
        w_start        = 1'b0;
        w_pop          = 1'b0;
        w_tx_next      = STOP_BIT;
        w_done_next    = 1'b0;

        case (r_state)
            IDLE: begin
                w_start = !w_empty;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                    w_timer_next = r_div;
                end else begin
                    w_timer_next = r_timer - 12'd1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_timer_next = r_div;
                    w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_timer_next = r_timer - 12'd1;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                    w_timer_next = r_div;
                end else begin
                    w_timer_next = r_timer - 12'd1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    // Chain straight into the next frame when data is waiting.
                    w_state_next = IDLE;
                    w_start      = !w_empty;
                end else begin
                    w_timer_next = r_timer - 12'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Frame start: pop the head and freeze the per-frame settings.
        if (w_start) begin
            w_pop          = 1'b1;
            w_state_next   = START;
            w_shift_next   = w_fifo_data;
            w_div_next     = WORK_FR;
            w_timer_next   = WORK_FR;
            w_bit_cnt_next = 3'd0;
            w_par_en_next  = PARITY_EN;
            w_par_next     = even_parity(w_fifo_data);
        end else begin
            w_pop          = 1'b0;
        end

        case (w_state_next)
            START:   w_tx_next = START_BIT;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_par_next;
            STOP:    w_tx_next = STOP_BIT;
            default: w_tx_next = STOP_BIT;
        endcase

        w_done_next = (w_state_next == STOP) && (w_timer_next == 12'd0);
    end

    // State and datapath registers, including the registered outputs.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_shift   <= 8'd0;
            r_div     <= 12'd0;
            r_timer   <= 12'd0;
            r_bit_cnt <= 3'd0;
            r_par_en  <= 1'b0;
            r_par     <= 1'b0;
            r_tx      <= STOP_BIT;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_div     <= w_div_next;
            r_timer   <= w_timer_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_par_en  <= w_par_en_next;
            r_par     <= w_par_next;
            r_tx      <= w_tx_next;
            r_done    <= w_done_next;
            r_busy    <= (w_state_next != IDLE);
        end
    end

    assign TX_O = r_tx;
    assign DONE = r_done;
    assign BUSY = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic,
// compared every cycle against a frame-level reference model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;

    logic        PCLK = 1'b0;
    logic        RESET;
    logic        WR_EN;
    logic [7:0]  DATA_TX_I;
    logic [11:0] WORK_FR;
    logic        PARITY_EN;
    logic        TX_O;
    logic        FULL;
    logic        EMPTY;
    logic [3:0]  COUNT;
    logic        BUSY;
    logic        DONE;
    logic        OVERFLOW;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .PCLK      (PCLK),
        .RESET     (RESET),
        .WR_EN     (WR_EN),
        .DATA_TX_I (DATA_TX_I),
        .WORK_FR   (WORK_FR),
        .PARITY_EN (PARITY_EN),
        .TX_O      (TX_O),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of bytes plus the bit list of the frame on the line.
    logic [7:0]  q[$];
    bit          m_active = 1'b0;
    bit [10:0]   m_bits;
    int          m_nbits  = 10;
    int          m_period = 1;
    int          m_cyc    = 0;
    bit          m_ovf    = 1'b0;
    bit          e_done   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit wr, input logic [7:0] d, input bit rst);
        int  c;
        bit  full;
        bit  start;
        logic [7:0] b;
        if (rst) begin
            q.delete();
            m_active = 1'b0;
            m_ovf    = 1'b0;
            m_cyc    = 0;
        end else begin
            c     = q.size();
            full  = (c == DEPTH);
            start = 1'b0;
            if (m_active) begin
                if (m_cyc == m_nbits * m_period - 1) begin
                    if (c > 0) start = 1'b1;
                    else       m_active = 1'b0;
                end else begin
                    m_cyc++;
                end
            end else if (c > 0) begin
                start = 1'b1;
            end
            if (start) begin
                b = q.pop_front();
                m_nbits = PARITY_EN ? 11 : 10;
                m_bits  = '0;
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
                if (PARITY_EN) m_bits[9] = ^b;
                m_bits[m_nbits-1] = 1'b1;
                m_period = int'(WORK_FR) + 1;
                m_cyc    = 0;
                m_active = 1'b1;
            end
            m_ovf = wr && full;
            if (wr && !full) q.push_back(d);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update the model, compare at the falling edge.
    task automatic step(input bit wr, input logic [7:0] d, input bit rst);
        int  e_tx;
        RESET     = rst;
        WR_EN     = wr;
        DATA_TX_I = d;
        @(posedge PCLK);
        model_edge(wr, d, rst);
        @(negedge PCLK);
        e_tx   = m_active ? int'(m_bits[m_cyc / m_period]) : 1;
        e_done = m_active && (m_cyc == m_nbits * m_period - 1);
        check("tx",       32'(TX_O),     32'(e_tx));
        check("busy",     32'(BUSY),     32'(m_active));
        check("done",     32'(DONE),     32'(e_done));
        check("count",    32'(COUNT),    32'(q.size()));
        check("full",     32'(FULL),     32'(q.size() == DEPTH));
        check("empty",    32'(EMPTY),    32'(q.size() == 0));
        check("overflow", 32'(OVERFLOW), 32'(m_ovf));
    endtask

    initial begin
        logic rx[$];
        logic [7:0] rx_byte;
        int busy_cnt;
        int done_cnt;
        int guard;

        RESET = 1'b1; WR_EN = 1'b0; DATA_TX_I = 8'h00; WORK_FR = 12'd0; PARITY_EN = 1'b0;
        @(negedge PCLK);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("reset_tx",    32'(TX_O),  32'd1);
        check("reset_empty", 32'(EMPTY), 32'd1);

        // 0xA5 with parity, 4-cycle bits, plus a mid-bit loopback decode.
        WORK_FR = 12'd3; PARITY_EN = 1'b1;
        step(1'b1, 8'hA5, 1'b0);
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (BUSY) begin busy_cnt++; rx.push_back(TX_O); end
            if (DONE) done_cnt++;
        end
        check("a5_len",  32'(busy_cnt), 32'd44);
        check("a5_done", 32'(done_cnt), 32'd1);
        if (rx.size() == 44) begin
            for (int k = 0; k < 8; k++) rx_byte[k] = rx[(k + 1) * 4 + 2];
            check("a5_loop",   32'(rx_byte), 32'h000000A5);
            check("a5_parity", 32'(rx_byte[0] ^ rx_byte[1] ^ rx_byte[2] ^ rx_byte[3] ^
                                   rx_byte[4] ^ rx_byte[5] ^ rx_byte[6] ^ rx_byte[7] ^ rx[38]), 32'd0);
            check("a5_start",  32'(rx[1]),  32'd0);
            check("a5_stop",   32'(rx[42]), 32'd1);
        end

        // Three back-to-back 10-cycle frames.
        WORK_FR = 12'd0; PARITY_EN = 1'b0;
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h80, 1'b0);
        busy_cnt = 1;
        step(1'b1, 8'hFF, 1'b0);
        busy_cnt += BUSY ? 1 : 0;
        for (int i = 0; i < 35; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (BUSY) busy_cnt++;
        end
        check("b2b_busy", 32'(busy_cnt), 32'd30);

        // Fill while busy: 8 accepted, 9th overflows; then push-while-full at a frame start.
        WORK_FR = 12'd3; PARITY_EN = 1'b0;
        step(1'b1, 8'h11, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        check("fill_count", 32'(COUNT),    32'd8);
        check("fill_ovf",   32'(OVERFLOW), 32'd1);
        guard = 0;
        while (!e_done && guard < 100) begin step(1'b0, 8'h00, 1'b0); guard++; end
        check("fill_wait", 32'(guard < 100), 32'd1);
        step(1'b1, 8'h99, 1'b0);
        check("pop_full_count", 32'(COUNT),    32'd7);
        check("pop_full_ovf",   32'(OVERFLOW), 32'd1);

        // Reset during data bit 4 of 0x3C with two bytes still queued.
        step(1'b0, 8'h00, 1'b1);
        WORK_FR = 12'd1; PARITY_EN = 1'b0;
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        guard = 0;
        while (!(m_active && m_cyc / m_period == 5) && guard < 100) begin
            step(1'b0, 8'h00, 1'b0); guard++;
        end
        check("rst_wait", 32'(guard < 100), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("rst_tx",    32'(TX_O),  32'd1);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_busy",  32'(BUSY),  32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (BUSY) busy_cnt++;
        end
        check("rst_idle", 32'(busy_cnt), 32'd0);

        // WORK_FR change mid-frame only affects the following frame.
        WORK_FR = 12'd3; PARITY_EN = 1'b0;
        step(1'b1, 8'h0F, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);
        WORK_FR = 12'd7;
        busy_cnt = 0;
        for (int i = 0; i < 130; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (BUSY) busy_cnt++;
        end
        check("wf_change_len", 32'(busy_cnt), 32'd29 + 32'd80);

        // Random traffic with varying divisor, parity and rare resets.
        for (int i = 0; i < 800; i++) begin
            WORK_FR   = 12'($urandom_range(0, 2));
            PARITY_EN = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: accepts bytes from the host through a write-enable port into an internal FIFO and serialises them on TX_O. Frame format is 1 start bit, 8 data bits LSB first, an optional even-parity bit, and 1 stop bit. It is the transmit counterpart of the existing receiver: it uses the same 12-bit WORK_FR bit-period control and the same parity convention as PARITY_RX, so a loopback of TX_O into the receiver reproduces DATA_TX_I. It sits beside the receiver inside the UART top and replaces single-byte START-driven transmission when the host bursts data.

## Interface
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), FIFO pointer width.
- PCLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- WR_EN  in  1  push DATA_TX_I into the FIFO this cycle.
- DATA_TX_I  in  8  byte to queue.
- WORK_FR  in  12  bit period = WORK_FR+1 PCLK cycles; sampled at each frame start.
- PARITY_EN  in  1  1 = append even-parity bit; sampled at each frame start.
- TX_O  out  1  serial line, idle high, registered.
- FULL  out  1  FIFO holds DEPTH entries.
- EMPTY  out  1  FIFO holds 0 entries.
- COUNT  out  AW+1  FIFO occupancy.
- BUSY  out  1  a frame is in progress (state != IDLE).
- DONE  out  1  one-cycle pulse on the last cycle of each stop bit.
- OVERFLOW  out  1  one-cycle pulse when WR_EN is dropped because FULL.

## Operation
- Reset values: TX_O=1, FULL=0, EMPTY=1, COUNT=0, BUSY=0, DONE=0, OVERFLOW=0, state IDLE. FIFO pointers cleared; queued data discarded.
- Push: WR_EN && !FULL writes at wptr, wptr+1 (wraps mod DEPTH). WR_EN && FULL: data dropped, OVERFLOW=1 next cycle. FULL is evaluated on the pre-edge count; a simultaneous pop does not make room in the same cycle.
- Pop: occurs only at a frame start, reading rptr, then rptr+1 (wraps). Simultaneous push and pop leaves COUNT unchanged.
- State machine (package enum): IDLE, START, DATA, PARITY, STOP.
  - IDLE: if !EMPTY, pop the head into an 8-bit shift register, latch WORK_FR into a divisor register, latch PARITY_EN, compute parity = ^byte, go to START.
  - START: TX_O=0 for one bit period, then go to DATA.
  - DATA: TX_O = shift[0] for one bit period per bit, shifting right. A 3-bit counter runs 0..7; after bit 7, go to PARITY if parity is enabled, else STOP.
  - PARITY: TX_O = ^byte (even parity: total count of ones, including this bit, is even) for one bit period, then go to STOP.
  - STOP: TX_O=1 for one bit period. DONE is high in its last cycle. Then, if !EMPTY, pop and go directly to START (no idle gap); else go to IDLE.
- Bit timer: a 12-bit down-counter loaded with the latched divisor at every bit boundary; the bit ends when the counter reaches 0. WORK_FR=0 gives 1 cycle per bit. Changing WORK_FR or PARITY_EN mid-frame has no effect until the next frame.
- RESET mid-frame: TX_O=1 and state IDLE after the reset edge. The frame is truncated and the FIFO is flushed.

## Timing
- Write at edge N with EMPTY and IDLE: COUNT=1 after edge N. Pop at edge N+1. TX_O=0 (start bit) from edge N+1. COUNT=0 after edge N+1.
- Frame length: (WORK_FR+1) × (10 + PARITY_EN) cycles.
- Back-to-back frames: the next start bit begins on the edge immediately after the stop bit's last cycle.
- All outputs are registered. TX_O has no combinational path from inputs.
- DONE and OVERFLOW are single-cycle pulses.

## Structure
- uart_pkg: tx_state_t enum (IDLE, START, DATA, PARITY, STOP), DATA_W=8, DIV_W=12, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module sync_fifo (DEPTH and width parameters; FULL, EMPTY, COUNT) is instantiated. The framing FSM and bit timer stay in uart_tx_fifo.

## Test plan
- WORK_FR=3, PARITY_EN=1, push 0xA5. Expect TX_O sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit held 4 cycles (44 cycles). DONE pulses once. Receiver loopback yields 0xA5 with PARITY_RX=0.
- WORK_FR=0, PARITY_EN=0, push 0x01,0x80,0xFF in consecutive cycles. Expect three 10-cycle frames with no idle gap. BUSY stays high for 30 cycles. EMPTY=1 after the third pop.
- Push 9 bytes in consecutive cycles while TX is busy (DEPTH=8). Expect FULL after 8 accepted bytes, OVERFLOW pulses on the 9th, and COUNT=8.
- Simultaneous push while FULL and pop at a frame start: the push is dropped, OVERFLOW pulses, COUNT=7.
- Assert RESET during DATA bit 4 of 0x3C with 2 bytes queued. Next cycle: TX_O=1, EMPTY=1, BUSY=0, and no further frames.
- Change WORK_FR from 3 to 7 mid-frame. The current frame keeps a 4-cycle bit period; the next frame uses 8.
